// File: rtl/axi_clint_responder.sv
// axi_clint_responder: single-beat AXI4 CLINT (msip, mtimecmp, mtime) for one hart,
// driving the machine timer/software interrupts and the rdtime value.
module axi_clint_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int unsigned TICK_DIV  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_awvalid,
  output logic        s_awready,
  input  logic [31:0] s_awaddr,
  input  logic [2:0]  s_awsize,
  input  logic        s_wvalid,
  output logic        s_wready,
  input  logic [63:0] s_wdata,
  input  logic [7:0]  s_wstrb,
  input  logic        s_wlast,
  output logic        s_bvalid,
  input  logic        s_bready,
  output logic [1:0]  s_bresp,
  input  logic        s_arvalid,
  output logic        s_arready,
  input  logic [31:0] s_araddr,
  input  logic [2:0]  s_arsize,
  output logic        s_rvalid,
  input  logic        s_rready,
  output logic [63:0] s_rdata,
  output logic [1:0]  s_rresp,
  output logic        s_rlast,
  output logic        timer_intr,
  output logic        sftwr_intr,
  output logic [63:0] rdtime
);
  localparam logic [12:0] SEL_MSIP = 13'h0000;
  localparam logic [12:0] SEL_CMP  = 13'h0800;
  localparam logic [12:0] SEL_TIME = 13'h17FF;
  logic        aw_q, w_q, bvalid_q, rvalid_q, msip_q, tintr_q, sintr_q;
  logic [1:0]  bresp_q, rresp_q;
  logic [31:0] awaddr_q, presc_q;
  logic [7:0]  wstrb_q;
  logic [63:0] wdata_q, rdata_q, mtime_q, mtimecmp_q;
  logic        aw_hs, w_hs, ar_hs, b_hs, do_wr, tick, w_win, r_win, w_hit, r_hit;
  logic [31:0] wa, woff, roff;
  logic [7:0]  ws;
  logic [63:0] wd, inc, rd, mtime_d;
  logic [12:0] wsel, rsel;
  logic        unused;
  function automatic logic [63:0] merge(input logic [63:0] o, input logic [63:0] n,
                                        input logic [7:0] s);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i+:8] = s[i] ? n[8*i+:8] : o[8*i+:8];
    return r;
  endfunction
  always_comb begin
    aw_hs   = s_awvalid & !aw_q;
    w_hs    = s_wvalid & !w_q;
    ar_hs   = s_arvalid & !rvalid_q;
    b_hs    = bvalid_q & s_bready;
    wa      = aw_q ? awaddr_q : s_awaddr;
    wd      = w_q ? wdata_q : s_wdata;
    ws      = w_q ? wstrb_q : s_wstrb;
    // Fires once: both halves present and no response still owed
    do_wr   = (aw_q | aw_hs) & (w_q | w_hs) & !bvalid_q;
    woff    = wa - BASE_ADDR;
    roff    = s_araddr - BASE_ADDR;
    wsel    = woff[15:3];
    rsel    = roff[15:3];
    w_win   = woff[31:16] == 16'h0;
    r_win   = roff[31:16] == 16'h0;
    w_hit   = w_win & (wsel == SEL_MSIP || wsel == SEL_CMP || wsel == SEL_TIME);
    r_hit   = r_win & (rsel == SEL_MSIP || rsel == SEL_CMP || rsel == SEL_TIME);
    rd      = !r_win ? 64'h0 :
              rsel == SEL_MSIP ? {63'h0, msip_q} :
              rsel == SEL_CMP  ? mtimecmp_q :
              rsel == SEL_TIME ? mtime_q : 64'h0;
    tick    = presc_q == 32'(TICK_DIV - 1);
    inc     = mtime_q + {63'h0, tick};
    mtime_d = (do_wr && w_win && wsel == SEL_TIME) ? merge(inc, wd, ws) : inc;
    unused  = ^{s_awsize, s_wlast, s_arsize, woff[2:0], roff[2:0]};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      aw_q       <= 1'b0;
      w_q        <= 1'b0;
      awaddr_q   <= 32'h0;
      wdata_q    <= 64'h0;
      wstrb_q    <= 8'h0;
      bvalid_q   <= 1'b0;
      bresp_q    <= 2'b00;
      rvalid_q   <= 1'b0;
      rdata_q    <= 64'h0;
      rresp_q    <= 2'b00;
      presc_q    <= 32'h0;
      mtime_q    <= 64'h0;
      mtimecmp_q <= '1;
      msip_q     <= 1'b0;
      tintr_q    <= 1'b0;
      sintr_q    <= 1'b0;
    end else begin
      aw_q     <= (aw_q | aw_hs) & !b_hs;
      w_q      <= (w_q | w_hs) & !b_hs;
      if (aw_hs) awaddr_q <= s_awaddr;
      if (w_hs) begin
        wdata_q <= s_wdata;
        wstrb_q <= s_wstrb;
      end
      if (do_wr) bresp_q <= w_hit ? 2'b00 : 2'b11;
      bvalid_q <= do_wr | (bvalid_q & !s_bready);
      if (ar_hs) begin
        rdata_q <= rd;
        rresp_q <= r_hit ? 2'b00 : 2'b11;
      end
      rvalid_q <= ar_hs | (rvalid_q & !s_rready);
      presc_q  <= tick ? 32'h0 : presc_q + 32'h1;
      mtime_q  <= mtime_d;
      if (do_wr && w_win && wsel == SEL_CMP) mtimecmp_q <= merge(mtimecmp_q, wd, ws);
      if (do_wr && w_win && wsel == SEL_MSIP && ws[0]) msip_q <= wd[0];
      tintr_q  <= mtime_q >= mtimecmp_q;
      sintr_q  <= msip_q;
    end
  end
  assign s_awready  = !aw_q;
  assign s_wready   = !w_q;
  assign s_bvalid   = bvalid_q;
  assign s_bresp    = bresp_q;
  assign s_arready  = !rvalid_q;
  assign s_rvalid   = rvalid_q;
  assign s_rdata    = rdata_q;
  assign s_rresp    = rresp_q;
  assign s_rlast    = rvalid_q;
  assign timer_intr = tintr_q;
  assign sftwr_intr = sintr_q;
  assign rdtime     = mtime_q;
endmodule

// File: tb/tb_axi_clint_responder.sv
// tb_axi_clint_responder: directed tests of the CLINT responder with hand-computed expectations.
module tb_axi_clint_responder;
  localparam logic [31:0] BASE = 32'h0200_0000;
  localparam logic [31:0] A_MSIP = BASE, A_CMP = BASE + 32'h4000, A_TIME = BASE + 32'hBFF8;
  logic clk = 1'b0, reset;
  logic s_awvalid, s_awready, s_wvalid, s_wready, s_wlast, s_bvalid, s_bready;
  logic s_arvalid, s_arready, s_rvalid, s_rready, s_rlast, timer_intr, sftwr_intr;
  logic [31:0] s_awaddr, s_araddr;
  logic [2:0] s_awsize, s_arsize;
  logic [63:0] s_wdata, s_rdata, rdtime;
  logic [7:0] s_wstrb;
  logic [1:0] s_bresp, s_rresp;
  int total = 0, bad = 0;
  axi_clint_responder #(.BASE_ADDR(BASE), .TICK_DIV(1)) dut (
    .clk(clk), .reset(reset),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awsize(s_awsize),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_wlast(s_wlast), .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arsize(s_arsize),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .s_rlast(s_rlast), .timer_intr(timer_intr), .sftwr_intr(sftwr_intr), .rdtime(rdtime)
  );
  always #5 clk = ~clk;
  task automatic do_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                          output logic [1:0] resp, output logic sb);
    int n = 0;
    s_awvalid = 1; s_awaddr = a; s_wvalid = 1; s_wdata = d; s_wstrb = s;
    @(negedge clk); s_awvalid = 0; s_wvalid = 0;
    while (!s_bvalid && n < 20) begin @(negedge clk); n++; end
    total++; if (n >= 20) begin bad++; $display("FAIL write_timeout: bvalid=%b required 1", s_bvalid); end
    resp = s_bresp; sb = sftwr_intr;
    s_bready = 1; @(negedge clk); s_bready = 0;
  endtask
  task automatic do_read(input logic [31:0] a, output logic [63:0] d, output logic [1:0] r,
                         output logic lst);
    int n = 0;
    s_arvalid = 1; s_araddr = a;
    @(negedge clk); s_arvalid = 0;
    while (!s_rvalid && n < 20) begin @(negedge clk); n++; end
    total++; if (n >= 20) begin bad++; $display("FAIL read_timeout: rvalid=%b required 1", s_rvalid); end
    d = s_rdata; r = s_rresp; lst = s_rlast;
    s_rready = 1; @(negedge clk); s_rready = 0;
  endtask
  task automatic test_reset;
    logic [63:0] d; logic [1:0] r; logic l;
    reset = 1; repeat (3) @(negedge clk);
    total++; if (rdtime !== 64'h0) begin bad++; $display("FAIL rst_mtime: got %h want 0", rdtime); end
    total++; if ({s_awready, s_wready, s_arready} !== 3'b111) begin bad++; $display("FAIL rst_ready: got %b want 111", {s_awready, s_wready, s_arready}); end
    total++; if ({s_bvalid, s_rvalid, timer_intr, sftwr_intr} !== 4'b0) begin bad++; $display("FAIL rst_flags: got %b want 0000", {s_bvalid, s_rvalid, timer_intr, sftwr_intr}); end
    total++; if ({s_bresp, s_rresp, s_rdata} !== 68'h0) begin bad++; $display("FAIL rst_data: got %h want 0", {s_bresp, s_rresp, s_rdata}); end
    reset = 0; repeat (10) @(negedge clk);
    total++; if (rdtime !== 64'd10) begin bad++; $display("FAIL idle_mtime: got %0d want 10", rdtime); end
    total++; if ({timer_intr, sftwr_intr} !== 2'b00) begin bad++; $display("FAIL idle_intr: got %b want 00", {timer_intr, sftwr_intr}); end
    do_read(A_TIME, d, r, l);
    total++; if (d !== 64'd10) begin bad++; $display("FAIL read_mtime: got %0d want 10", d); end
    total++; if ({r, l} !== 3'b001) begin bad++; $display("FAIL read_mtime_resp: got %b want 001", {r, l}); end
  endtask
  task automatic test_msip;
    logic [1:0] r; logic sb, l; logic [63:0] d;
    do_write(A_MSIP, 64'h1, 8'h01, r, sb);
    total++; if (r !== 2'b00) begin bad++; $display("FAIL msip_bresp: got %b want 00", r); end
    total++; if (sb !== 1'b0) begin bad++; $display("FAIL msip_early: got %b want 0", sb); end
    total++; if (sftwr_intr !== 1'b1) begin bad++; $display("FAIL msip_set: got %b want 1", sftwr_intr); end
    do_write(A_MSIP, 64'h0, 8'h01, r, sb);
    total++; if (sftwr_intr !== 1'b0) begin bad++; $display("FAIL msip_clr: got %b want 0", sftwr_intr); end
    do_write(A_MSIP, '1, 8'hFE, r, sb);
    total++; if (sftwr_intr !== 1'b0) begin bad++; $display("FAIL msip_nostrb: got %b want 0", sftwr_intr); end
    do_write(A_MSIP, '1, 8'hFF, r, sb);
    do_read(A_MSIP, d, r, l);
    total++; if (d !== 64'h1) begin bad++; $display("FAIL msip_read: got %h want 1", d); end
    do_write(A_MSIP, 64'h0, 8'h01, r, sb);
  endtask
  task automatic test_timer;
    logic [1:0] r; logic sb; int n = 0;
    do_write(A_CMP, 64'd100, 8'hFF, r, sb);
    do_write(A_TIME, 64'd40, 8'hFF, r, sb);
    total++; if (rdtime !== 64'd41) begin bad++; $display("FAIL mtime_wr: got %0d want 41", rdtime); end
    while (rdtime !== 64'd100 && n < 200) begin @(negedge clk); n++; end
    total++; if (n >= 200) begin bad++; $display("FAIL timer_wait: rdtime=%0d want 100", rdtime); end
    total++; if (timer_intr !== 1'b0) begin bad++; $display("FAIL timer_at100: got %b want 0", timer_intr); end
    @(negedge clk);
    total++; if ({rdtime, timer_intr} !== {64'd101, 1'b1}) begin bad++; $display("FAIL timer_rise: got %0d/%b want 101/1", rdtime, timer_intr); end
    do_write(A_CMP, '1, 8'hFF, r, sb);
    total++; if (timer_intr !== 1'b0) begin bad++; $display("FAIL timer_drop: got %b want 0", timer_intr); end
  endtask
  task automatic test_back_to_back;
    logic [63:0] d; logic [1:0] r; logic l;
    s_wvalid = 1; s_wdata = 64'h1; s_wstrb = 8'h01;
    @(negedge clk); s_wvalid = 0;
    total++; if ({s_wready, s_awready, s_bvalid} !== 3'b010) begin bad++; $display("FAIL w_first: got %b want 010", {s_wready, s_awready, s_bvalid}); end
    repeat (2) @(negedge clk);
    s_awvalid = 1; s_awaddr = A_MSIP;
    @(negedge clk); s_awvalid = 0;
    total++; if ({s_bvalid, s_bresp} !== 3'b100) begin bad++; $display("FAIL aw_late_b: got %b want 100", {s_bvalid, s_bresp}); end
    s_awvalid = 1; s_awaddr = A_CMP; s_wvalid = 1; s_wdata = 64'hFFFF_FFFF_0000_0000; s_wstrb = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if ({s_bvalid, s_bresp, s_awready, s_wready} !== 5'b10000) begin bad++; $display("FAIL b_hold%0d: got %b want 10000", i, {s_bvalid, s_bresp, s_awready, s_wready}); end
    end
    total++; if (sftwr_intr !== 1'b1) begin bad++; $display("FAIL b2b_msip: got %b want 1", sftwr_intr); end
    s_bready = 1; @(negedge clk); s_bready = 0;
    total++; if ({s_bvalid, s_awready, s_wready} !== 3'b011) begin bad++; $display("FAIL b_release: got %b want 011", {s_bvalid, s_awready, s_wready}); end
    @(negedge clk); s_awvalid = 0; s_wvalid = 0;
    total++; if (s_bvalid !== 1'b1) begin bad++; $display("FAIL second_b: got %b want 1", s_bvalid); end
    s_bready = 1; @(negedge clk); s_bready = 0;
    do_read(A_CMP, d, r, l);
    total++; if (d !== 64'hFFFF_FFFF_0000_0000) begin bad++; $display("FAIL second_wr: got %h want ffffffff00000000", d); end
  endtask
  task automatic test_decerr;
    logic [63:0] d; logic [1:0] r; logic sb, l;
    do_write(BASE + 32'h8000, '1, 8'hFF, r, sb);
    total++; if (r !== 2'b11) begin bad++; $display("FAIL hole_bresp: got %b want 11", r); end
    do_read(BASE + 32'h8000, d, r, l);
    total++; if ({r, d} !== {2'b11, 64'h0}) begin bad++; $display("FAIL hole_read: got %b/%h want 11/0", r, d); end
    do_write(BASE - 32'h8, 64'h0, 8'hFF, r, sb);
    total++; if (r !== 2'b11) begin bad++; $display("FAIL below_bresp: got %b want 11", r); end
    do_read(BASE - 32'h8, d, r, l);
    total++; if ({r, d} !== {2'b11, 64'h0}) begin bad++; $display("FAIL below_read: got %b/%h want 11/0", r, d); end
    do_read(A_CMP, d, r, l);
    total++; if (d !== 64'hFFFF_FFFF_0000_0000) begin bad++; $display("FAIL decerr_cmp: got %h want ffffffff00000000", d); end
    total++; if (sftwr_intr !== 1'b1) begin bad++; $display("FAIL decerr_msip: got %b want 1", sftwr_intr); end
  endtask
  task automatic test_merge_reset;
    logic [63:0] d; logic [1:0] r; logic sb, l;
    do_write(A_TIME, 64'h1122_3344_5566_77FE, 8'hFF, r, sb);
    total++; if (rdtime !== 64'h1122_3344_5566_77FF) begin bad++; $display("FAIL mtime_full: got %h want 11223344556677ff", rdtime); end
    s_awvalid = 1; s_awaddr = A_TIME; s_wvalid = 1; s_wdata = 64'hFF; s_wstrb = 8'h01;
    @(negedge clk); s_awvalid = 0; s_wvalid = 0;
    total++; if (rdtime !== 64'h1122_3344_5566_78FF) begin bad++; $display("FAIL mtime_merge: got %h want 11223344556678ff", rdtime); end
    s_arvalid = 1; s_araddr = A_TIME;
    @(negedge clk); s_arvalid = 0;
    total++; if ({s_rvalid, s_rdata} !== {1'b1, 64'h1122_3344_5566_78FF}) begin bad++; $display("FAIL pend_read: got %b/%h want 1/11223344556678ff", s_rvalid, s_rdata); end
    reset = 1; @(negedge clk); reset = 0;
    total++; if ({s_rvalid, s_bvalid, sftwr_intr, timer_intr} !== 4'b0) begin bad++; $display("FAIL mid_rst_flags: got %b want 0000", {s_rvalid, s_bvalid, sftwr_intr, timer_intr}); end
    total++; if ({rdtime, s_rdata} !== 128'h0) begin bad++; $display("FAIL mid_rst_data: got %h/%h want 0/0", rdtime, s_rdata); end
    total++; if ({s_awready, s_wready, s_arready} !== 3'b111) begin bad++; $display("FAIL mid_rst_ready: got %b want 111", {s_awready, s_wready, s_arready}); end
    do_read(A_CMP, d, r, l);
    total++; if (d !== '1) begin bad++; $display("FAIL rst_cmp: got %h want ffffffffffffffff", d); end
    do_read(A_MSIP, d, r, l);
    total++; if (d !== 64'h0) begin bad++; $display("FAIL rst_msip: got %h want 0", d); end
  endtask
  initial begin
    reset = 1; s_awvalid = 0; s_awaddr = 0; s_awsize = 3'd3; s_wvalid = 0; s_wdata = 0;
    s_wstrb = 0; s_wlast = 1; s_bready = 0; s_arvalid = 0; s_araddr = 0; s_arsize = 3'd3;
    s_rready = 0;
    @(negedge clk);
    test_reset;
    test_msip;
    test_timer;
    test_back_to_back;
    test_decerr;
    test_merge_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
